// File: rtl/attn_ctrl_pkg.sv
// Shared definitions for the attention-engine sequencer: FSM state encoding,
// operand-count constants and the load-index to operand select helper.
package attn_ctrl_pkg;

  localparam int DEF_WORDS  = 32;
  localparam int DEF_DW     = 16;
  localparam int OPERANDS   = 3;
  localparam int LOAD_WORDS = OPERANDS * DEF_WORDS;

  // Sequencer states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_CLEAR = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  typedef enum logic [1:0] {
    OP_KEY   = 2'd0,
    OP_QUERY = 2'd1,
    OP_VALUE = 2'd2,
    OP_NONE  = 2'd3
  } operand_e;

  // Words arrive key first, then query, then value, each `words` long.
  function automatic operand_e idx_to_operand(input int unsigned idx,
                                              input int unsigned words);
    if (idx < words)          return OP_KEY;
    else if (idx < 2 * words) return OP_QUERY;
    else if (idx < 3 * words) return OP_VALUE;
    else                      return OP_NONE;
  endfunction

endpackage

// File: rtl/attn_res_serializer.sv
// Result serializer: captures the engine's packed result and streams it out
// one word at a time over valid/ready, word 0 first.
// Handshake: a word transfers on a rising edge where out_valid && out_ready;
// out_data/out_last are held stable while out_valid is high and out_ready low.
module attn_res_serializer #(
  parameter int WORDS = 32,
  parameter int DW    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [WORDS*DW-1:0] res_in,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [DW-1:0]       out_data,
  output logic                out_last,
  output logic                last_hs
);

  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  logic [WORDS*DW-1:0] res_q;
  logic [KW-1:0]       k;

  // Capture on load, then advance the word pointer on every accepted word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q     <= '0;
      k         <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      res_q     <= res_in;
      k         <= '0;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      if (k == K_LAST) begin
        k         <= '0;
        out_valid <= 1'b0;
      end else begin
        k <= k + 1'b1;
      end
    end
  end

  assign out_data = res_q[k*DW +: DW];
  assign out_last = out_valid && (k == K_LAST);
  assign last_hs  = out_valid && out_ready && (k == K_LAST);

endmodule

// File: rtl/attn_seq_ctrl.sv
// Sequencer for the 8x8 PE attention engine: packs a 16-bit word stream into
// key/query/value buses, clears and runs the engine with a timeout, then
// streams the captured result out.
// Optional macro ATTN_CYCLE_CNT_EN adds run_cycles, the RUN length of the last
// completed job.
// Input handshake: a word is taken on a rising edge with in_valid && in_ready.
module attn_seq_ctrl
  import attn_ctrl_pkg::*;
#(
  parameter int WORDS      = DEF_WORDS,
  parameter int DW         = DEF_DW,
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW-1:0]       in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_data,
  output logic                out_last,
  output logic [WORDS*DW-1:0] eng_key,
  output logic [WORDS*DW-1:0] eng_query,
  output logic [WORDS*DW-1:0] eng_value,
  output logic                eng_en,
  output logic                eng_rst_n,
  input  logic [WORDS*DW-1:0] eng_res,
  input  logic                eng_done,
  output logic                busy,
  output logic                job_done,
  output logic                err_timeout
`ifdef ATTN_CYCLE_CNT_EN
  ,
  output logic [31:0]         run_cycles
`endif
);

  localparam int LW     = OPERANDS * WORDS;
  localparam int IDX_W  = $clog2(LW);
  localparam int SLOT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CLR_W  = $clog2(CLR_CYCLES + 1);

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(LW - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(WORDS - 1);
  localparam logic [CLR_W-1:0]  CLR_LAST  = CLR_W'(CLR_CYCLES - 1);
  localparam logic [31:0]       RUN_LAST  = 32'(TIMEOUT - 1);

  logic [2:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [SLOT_W-1:0] slot;
  logic [CLR_W-1:0]  clr_cnt;
  logic [31:0]       run_cnt;
  logic              res_load;
  logic              last_hs;

  assign in_ready  = (state == ST_LOAD);
  assign busy      = (state != ST_IDLE);
  assign eng_en    = (state == ST_RUN);
  assign eng_rst_n = (state == ST_RUN);
  assign res_load  = (state == ST_RUN) && eng_done;

  // Main sequencer: load, clear, run with timeout, drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      slot        <= '0;
      clr_cnt     <= '0;
      run_cnt     <= '0;
      eng_key     <= '0;
      eng_query   <= '0;
      eng_value   <= '0;
      job_done    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      job_done    <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          // job_done still high means the previous job just finished
          if (start && !job_done) begin
            state <= ST_LOAD;
            idx   <= '0;
            slot  <= '0;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            case (idx_to_operand(32'(idx), WORDS))
              OP_KEY:   eng_key[slot*DW +: DW]   <= in_data;
              OP_QUERY: eng_query[slot*DW +: DW] <= in_data;
              OP_VALUE: eng_value[slot*DW +: DW] <= in_data;
              default:  ;
            endcase
            slot <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
            idx  <= idx + 1'b1;
            if (idx == IDX_LAST) begin
              state   <= ST_CLEAR;
              clr_cnt <= '0;
            end
          end
        end
        ST_CLEAR: begin
          if (clr_cnt == CLR_LAST) begin
            state   <= ST_RUN;
            run_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          // done takes priority over a timeout expiring in the same cycle
          if (eng_done) begin
            state <= ST_DRAIN;
          end else if (run_cnt == RUN_LAST) begin
            err_timeout <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (last_hs) begin
            job_done <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ATTN_CYCLE_CNT_EN
  // Latch the RUN length (inclusive of the done cycle) of completed jobs only
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           run_cycles <= '0;
    else if (res_load) run_cycles <= run_cnt + 32'd1;
  end
`endif

  attn_res_serializer #(
    .WORDS (WORDS),
    .DW    (DW)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (res_load),
    .res_in    (eng_res),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .last_hs   (last_hs)
  );

endmodule

// File: tb/tb_attn_seq_ctrl.sv
// Bench for attn_seq_ctrl: directed jobs with a behavioural engine, a result
// scoreboard fed at job issue and drained by a negedge monitor, plus a second
// instance built with a short timeout.
module tb_attn_seq_ctrl;

  localparam int WORDS = 32;
  localparam int DW    = 16;
  localparam int BW    = WORDS * DW;
  localparam int ENG_LAT = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT signals ----------------
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid, out_last;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [BW-1:0] eng_key, eng_query, eng_value, eng_res;
  logic          eng_en, eng_rst_n, eng_done;
  logic          busy, job_done, err_timeout;

  // ---------------- timeout DUT signals ----------------
  logic          t_start = 1'b0;
  logic          t_in_ready, t_out_valid, t_out_last;
  logic          t_out_ready = 1'b1;
  logic [DW-1:0] t_out_data;
  logic [BW-1:0] t_eng_key, t_eng_query, t_eng_value;
  logic [BW-1:0] t_eng_res = '0;
  logic          t_eng_en, t_eng_rst_n;
  logic          t_eng_done = 1'b0;
  logic          t_busy, t_job_done, t_err_timeout;

`ifdef ATTN_CYCLE_CNT_EN
  logic [31:0] run_cycles, t_run_cycles;
`endif

  attn_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .eng_key(eng_key), .eng_query(eng_query), .eng_value(eng_value),
    .eng_en(eng_en), .eng_rst_n(eng_rst_n), .eng_res(eng_res), .eng_done(eng_done),
    .busy(busy), .job_done(job_done), .err_timeout(err_timeout)
`ifdef ATTN_CYCLE_CNT_EN
    , .run_cycles(run_cycles)
`endif
  );

  attn_seq_ctrl #(.TIMEOUT(16)) dut_to (
    .clk(clk), .rst(rst), .start(t_start),
    .in_valid(in_valid), .in_ready(t_in_ready), .in_data(in_data),
    .out_valid(t_out_valid), .out_ready(t_out_ready), .out_data(t_out_data), .out_last(t_out_last),
    .eng_key(t_eng_key), .eng_query(t_eng_query), .eng_value(t_eng_value),
    .eng_en(t_eng_en), .eng_rst_n(t_eng_rst_n), .eng_res(t_eng_res), .eng_done(t_eng_done),
    .busy(t_busy), .job_done(t_job_done), .err_timeout(t_err_timeout)
`ifdef ATTN_CYCLE_CNT_EN
    , .run_cycles(t_run_cycles)
`endif
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hand-chosen vectors: input word j of job n is A000 + n*100 + j,
  // result word k of job n is 5000 + n*100 + k.
  function automatic logic [DW-1:0] in_word(input int job, input int j);
    return DW'(32'hA000 + job * 256 + j);
  endfunction

  function automatic logic [DW-1:0] res_word(input int job, input int k);
    return DW'(32'h5000 + job * 256 + k);
  endfunction

  // ---------------- behavioural engine ----------------
  logic [BW-1:0] res_pat = '0;
  logic [31:0]   eng_cnt = '0;
  logic          early_mode = 1'b0;

  always @(posedge clk) begin
    if (!eng_rst_n)  eng_cnt <= '0;
    else if (eng_en) eng_cnt <= eng_cnt + 1;
  end

  // done in the ENG_LAT-th enabled cycle; early_mode also raises it whenever
  // the engine is held in reset (covers CLEAR)
  assign eng_done = early_mode ? (!eng_rst_n || (eng_cnt >= ENG_LAT - 1))
                               : (eng_rst_n && (eng_cnt >= ENG_LAT - 1));
  // result only valid in the done cycle, so a late or early capture shows up
  assign eng_res = (eng_done && eng_en) ? res_pat : ~res_pat;

  // ---------------- scoreboard + monitor ----------------
  logic [DW:0] exp_q[$];
  int mon_k      = 0;
  int stall_word = -1;
  int stall_left = 0;

  always @(negedge clk) begin
    logic [DW:0] e;
    if (out_valid && mon_k == stall_word && stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else begin
      out_ready = 1'b1;
    end
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got data %0h with no expected word", out_data);
      end else if (out_ready) begin
        e = exp_q.pop_front();
        check("out_word", {out_last, out_data}, e);
        mon_k = (mon_k + 1) % WORDS;
      end else begin
        check("stall_hold", {out_last, out_data}, exp_q[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input bit sel);
    @(posedge clk); #1;
    if (sel) t_start = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    t_start = 1'b0;
    start   = 1'b0;
  endtask

  task automatic load_words(input int job, input int n, input bit bubbles,
                            input bit sel, output int got);
    int  cyc;
    bit  hs;
    cyc = 0;
    got = 0;
    while (got < n && cyc < 1000) begin
      in_valid = bubbles ? (cyc % 2 == 0) : 1'b1;
      in_data  = in_word(job, got);
      @(negedge clk);
      hs = in_valid && (sel ? t_in_ready : in_ready);
      @(posedge clk); #1;
      if (hs) got++;
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_job(input int job, input bit bubbles, input bit stall);
    int got, clr_n, en_n, jd_n;
    bit seen_en, finished;
    for (int k = 0; k < WORDS; k++) begin
      res_pat[k*DW +: DW] = res_word(job, k);
      exp_q.push_back({(k == WORDS - 1), res_word(job, k)});
    end
    stall_word = stall ? 7 : -1;
    stall_left = stall ? 5 : 0;
    pulse_start(1'b0);
    load_words(job, 3 * WORDS, bubbles, 1'b0, got);
    check("load_count", got, 3 * WORDS);
    clr_n = 0; en_n = 0; jd_n = 0; seen_en = 0; finished = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("clear_in_ready_low", in_ready, 1'b0);
        check("clear_eng_rst_n_low", eng_rst_n, 1'b0);
        check("clear_busy", busy, 1'b1);
      end
      if (eng_en) begin
        en_n++;
        seen_en = 1;
      end else if (!seen_en) begin
        clr_n++;
      end
      if (job_done) begin
        jd_n++;
        start = 1'b1;  // must be ignored alongside job_done
      end else begin
        start = 1'b0;
        if (jd_n > 0) begin
          check("start_with_job_done_ignored", busy, 1'b0);
          check("out_valid_low_after_last", out_valid, 1'b0);
          finished = 1;
          break;
        end
      end
    end
    start = 1'b0;
    check("job_finished_in_budget", finished, 1'b1);
    check("clear_cycles", clr_n, 2);
    check("eng_en_cycles", en_n, ENG_LAT);
    check("job_done_pulses", jd_n, 1);
    check("results_drained", exp_q.size(), 0);
    for (int i = 0; i < WORDS; i++) begin
      check("eng_key_word",   eng_key[i*DW +: DW],   in_word(job, i));
      check("eng_query_word", eng_query[i*DW +: DW], in_word(job, WORDS + i));
      check("eng_value_word", eng_value[i*DW +: DW], in_word(job, 2 * WORDS + i));
    end
`ifdef ATTN_CYCLE_CNT_EN
    check("run_cycles", run_cycles, ENG_LAT);
`endif
  endtask

  task automatic timeout_job();
    int got, en_n, err_n, err_at;
    bit ov;
    pulse_start(1'b1);
    load_words(9, 3 * WORDS, 1'b0, 1'b1, got);
    check("to_load_count", got, 3 * WORDS);
    en_n = 0; err_n = 0; err_at = -1; ov = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (t_eng_en) en_n++;
      if (t_out_valid) ov = 1;
      if (t_err_timeout) begin
        err_n++;
        if (err_at < 0) err_at = c;
      end
    end
    check("to_run_cycles", en_n, 16);
    check("to_err_pulses", err_n, 1);
    check("to_err_cycle", err_at, 18);
    check("to_no_out_valid", ov, 1'b0);
    check("to_idle", t_busy, 1'b0);
    check("to_eng_rst_n", t_eng_rst_n, 1'b0);
    check("to_job_done", t_job_done, 1'b0);
`ifdef ATTN_CYCLE_CNT_EN
    check("to_run_cycles_held", t_run_cycles, 0);
`endif
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int got;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_job_done", job_done, 1'b0);
    check("rst_err_timeout", err_timeout, 1'b0);
    check("rst_eng_en", eng_en, 1'b0);
    check("rst_eng_rst_n", eng_rst_n, 1'b0);
    check("rst_eng_key", |eng_key, 1'b0);
    check("rst_eng_value", |eng_value, 1'b0);
    check("rst_to_busy", t_busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_job(1, 1'b0, 1'b0);   // basic job
    run_job(2, 1'b1, 1'b0);   // input bubbles
    run_job(3, 1'b0, 1'b1);   // output backpressure at word 7
    timeout_job();

    // abort in LOAD after index 40 has been accepted
    pulse_start(1'b0);
    load_words(4, 41, 1'b0, 1'b0, got);
    check("abort_load_count", got, 41);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_in_ready", in_ready, 1'b0);
    check("abort_eng_key", |eng_key, 1'b0);
    check("abort_eng_query", |eng_query, 1'b0);
    check("abort_eng_rst_n", eng_rst_n, 1'b0);
    check("abort_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_stays_idle", busy, 1'b0);

    early_mode = 1'b1;        // eng_done high through CLEAR
    run_job(5, 1'b0, 1'b0);
    early_mode = 1'b0;

    repeat (5) @(posedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
